// File: rtl/lif_spike_controller_if.sv
// Accumulator command bus between the LIF spike controller and the
// membrane accumulator: add/sub/load commands out, threshold flag back.
interface lif_spike_controller_if #(
  parameter int WIDTH = 8
);
  logic             add_en;
  logic             sub_en;
  logic             load_reset;
  logic [WIDTH-1:0] add;
  logic [WIDTH-1:0] sub;
  logic             thresh_hit;

  modport master (
    output add_en, sub_en, load_reset, add, sub,
    input  thresh_hit
  );

  modport slave (
    input  add_en, sub_en, load_reset, add, sub,
    output thresh_hit
  );
endinterface

// File: rtl/lif_spike_controller.sv
// LIF neuron control FSM: turns spikes and periodic leak into accumulator
// commands, fires on threshold, clamps during refractory, counts events.
module lif_spike_controller #(
  parameter int WIDTH         = 8,
  parameter int LEAK_PERIOD   = 4,
  parameter int REFRAC_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   spike_in,
  input  logic [WIDTH-1:0]       weight_in,
  input  logic [WIDTH-1:0]       leak_in,
  lif_spike_controller_if.master acc,
  output logic                   spike_out,
  output logic                   in_refrac,
  output logic [15:0]            spike_count,
  output logic [15:0]            drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    INTEGRATE,
    FIRE,
    REFRAC
  } state_t;

  localparam logic [7:0] LEAK_LAST   = 8'(LEAK_PERIOD - 1);
  localparam logic [7:0] REFRAC_INIT = 8'(REFRAC_CYCLES);

  state_t     state;
  logic [7:0] leak_timer;
  logic [7:0] refrac_cnt;
  logic       leak_pending;

  logic integ;
  logic live;
  logic tick;
  logic do_add;
  logic do_sub;
  logic clamp;
  logic drop;

  // Decode this cycle's command from registered state and live inputs.
  always_comb begin
    integ  = (state == INTEGRATE);
    live   = integ && !acc.thresh_hit;
    tick   = integ && (leak_timer == LEAK_LAST);
    do_add = live && spike_in;
    do_sub = live && !spike_in && (tick || leak_pending);
    clamp  = (state == FIRE) || (state == REFRAC);
    drop   = enable && spike_in && !live;
  end

  assign acc.add_en     = do_add;
  assign acc.sub_en     = do_sub;
  assign acc.load_reset = clamp;
  assign acc.add        = do_add ? weight_in : '0;
  assign acc.sub        = do_sub ? leak_in : '0;
  assign spike_out      = (state == FIRE);
  assign in_refrac      = clamp;

  // State, leak timing, refractory countdown and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      leak_timer   <= '0;
      refrac_cnt   <= '0;
      leak_pending <= 1'b0;
      spike_count  <= '0;
      drop_count   <= '0;
    end else begin
      if (state == FIRE && spike_count != 16'hFFFF)
        spike_count <= spike_count + 16'd1;
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      leak_timer   <= '0;
      leak_pending <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: state <= INTEGRATE;
          INTEGRATE: begin
            leak_timer <= tick ? 8'd0 : leak_timer + 8'd1;
            if (acc.thresh_hit)
              state <= FIRE;
            else if (spike_in)
              leak_pending <= leak_pending || tick;
          end
          FIRE: begin
            if (REFRAC_CYCLES == 0) begin
              state <= INTEGRATE;
            end else begin
              state      <= REFRAC;
              refrac_cnt <= REFRAC_INIT;
            end
          end
          REFRAC: begin
            refrac_cnt <= refrac_cnt - 8'd1;
            if (refrac_cnt == 8'd1)
              state <= INTEGRATE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
